// File: rtl/pipe_stage_reg_if.sv
// Control/data bundle for pipe_stage_reg. The upstream side (master) drives
// enable, flush and the incoming payload. The register (slave) drives the
// last-stage payload, the occupancy and the stall count.
interface pipe_stage_reg_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 1,
  parameter int CNT_W = 16
);
  logic                         in_EN;
  logic                         in_FLUSH;
  logic                         in_valid;
  logic [WIDTH-1:0]             in_data;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic [$clog2(DEPTH+1)-1:0]   out_occ;
  logic [CNT_W-1:0]             out_stall_cnt;

  modport master (
    output in_EN, in_FLUSH, in_valid, in_data,
    input  out_valid, out_data, out_occ, out_stall_cnt
  );

  modport slave (
    input  in_EN, in_FLUSH, in_valid, in_data,
    output out_valid, out_data, out_occ, out_stall_cnt
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline boundary register: DEPTH chained stages of
// {valid, payload}, with stall (in_EN=0), synchronous flush and bubble
// insertion. Bubbles always carry CLR_VALUE, so they are true NOPs.
// The optional saturating stall counter is enabled by defining
// PIPE_STAGE_STALL_CNT_EN. Without it, out_stall_cnt is tied to zero.
module pipe_stage_reg #(
  parameter int               WIDTH     = 64,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0,
  parameter int               CNT_W     = 16
) (
  input  logic               in_CLK,
  input  logic               in_CLR,
  pipe_stage_reg_if.slave    bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [OCC_W-1:0] w_occ;

  // Stage shift: reset/flush clear every stage; enable shifts toward the output.
  always_ff @(posedge in_CLK or posedge in_CLR) begin
    // NOTE: the payload array is reset, not only the valid bits. out_data must
    // read CLR_VALUE from reset onward, and downstream decode may look at it.
    if (in_CLR) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= CLR_VALUE;
    end else if (bus.in_FLUSH) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) r_d[k] <= CLR_VALUE;
    end else if (bus.in_EN) begin
      // NOTE: non-blocking assignments let every stage sample its predecessor's
      // old value, so the loop order does not matter.
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k] <= r_v[k-1];
        r_d[k] <= r_d[k-1];
      end
      r_v[0] <= bus.in_valid;
      // Gating on in_valid keeps X or garbage on in_data out of the pipe.
      r_d[0] <= bus.in_valid ? bus.in_data : CLR_VALUE;
    end
  end

  // Occupancy: popcount of the stage valid bits.
  always_comb begin
    // NOTE: the default assignment comes first so that no path through this
    // block leaves w_occ unassigned. Blocking '=' is correct in combinational logic.
    w_occ = '0;
    for (int k = 0; k < DEPTH; k++) w_occ = w_occ + OCC_W'(r_v[k]);
  end

  assign bus.out_valid = r_v[DEPTH-1];
  assign bus.out_data  = r_d[DEPTH-1];
  assign bus.out_occ   = w_occ;

`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;

  // Stall counter: counts stalled edges while the pipe holds something.
  // It saturates instead of wrapping. Only reset clears it, not flush.
  always_ff @(posedge in_CLK or posedge in_CLR) begin
    if (in_CLR) begin
      r_stall_cnt <= '0;
    end else if (!bus.in_FLUSH && !bus.in_EN && (w_occ != '0) &&
                 (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.out_stall_cnt = r_stall_cnt;
`else
  assign bus.out_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. One instance has DEPTH=2 and CNT_W=4,
// the other has DEPTH=1 and CNT_W=16. Both share the clock, reset and stimulus.
module tb_pipe_stage_reg;
  logic in_CLK;
  logic in_CLR;

  pipe_stage_reg_if #(.WIDTH(64), .DEPTH(2), .CNT_W(4))  if2 ();
  pipe_stage_reg_if #(.WIDTH(64), .DEPTH(1), .CNT_W(16)) if1 ();

  pipe_stage_reg #(.WIDTH(64), .DEPTH(2), .CLR_VALUE(64'h0), .CNT_W(4)) u_d2 (
    .in_CLK (in_CLK),
    .in_CLR (in_CLR),
    .bus    (if2.slave)
  );

  pipe_stage_reg #(.WIDTH(64), .DEPTH(1), .CLR_VALUE(64'h0), .CNT_W(16)) u_d1 (
    .in_CLK (in_CLK),
    .in_CLR (in_CLR),
    .bus    (if1.slave)
  );

  initial begin
    in_CLK = 1'b0;
    forever #5 in_CLK = ~in_CLK;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stall count that the build should show: the real value with the counter, 0 without.
  function automatic logic [63:0] cnt_exp(input int c);
`ifdef PIPE_STAGE_STALL_CNT_EN
    return 64'(c);
`else
    return 64'd0;
`endif
  endfunction

  task automatic drive(input logic en, input logic flush, input logic valid,
                       input logic [63:0] data);
    if2.in_EN = en; if2.in_FLUSH = flush; if2.in_valid = valid; if2.in_data = data;
    if1.in_EN = en; if1.in_FLUSH = flush; if1.in_valid = valid; if1.in_data = data;
  endtask

  task automatic edge_step();
    @(posedge in_CLK);
    #1;
  endtask

  typedef struct {
    logic        en;
    logic        flush;
    logic        valid;
    logic [63:0] data;
    logic        exp_v2;
    logic [63:0] exp_d2;
    int          exp_occ2;
    logic        exp_v1;
    logic [63:0] exp_d1;
    int          exp_cnt;
  } vec_t;

  localparam logic [63:0] PA = 64'h0000_0004_0000_0013;
  localparam logic [63:0] PB = 64'h0000_0008_0000_0033;
  localparam logic [63:0] PC = 64'h0000_0010_0000_0093;
  localparam logic [63:0] PD = 64'h0000_0014_0000_00B3;
  localparam logic [63:0] PE = 64'h0000_0018_0000_0013;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  vec_t vecs [16];

  initial begin
    //        en    fl    val   data      v2    d2     occ2 v1    d1     cnt
    vecs[0]  = '{1'b1, 1'b0, 1'b1, PA,       1'b0, 64'h0, 1, 1'b1, PA,    0}; // fill s0
    vecs[1]  = '{1'b1, 1'b0, 1'b1, PB,       1'b1, PA,    2, 1'b1, PB,    0}; // PA out after 2 edges
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 64'hAAAA, 1'b1, PA,    2, 1'b1, PB,    1}; // stall 1
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 64'hAAAA, 1'b1, PA,    2, 1'b1, PB,    2}; // stall 2
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 64'hAAAA, 1'b1, PA,    2, 1'b1, PB,    3}; // stall 3
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 64'h55,   1'b0, 64'h0, 0, 1'b0, 64'h0, 3}; // flush beats EN
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 64'h66,   1'b0, 64'h0, 0, 1'b0, 64'h0, 3}; // empty stall not counted
    vecs[7]  = '{1'b1, 1'b0, 1'b1, PC,       1'b0, 64'h0, 1, 1'b1, PC,    3};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, ONES,     1'b1, PC,    1, 1'b0, 64'h0, 3}; // bubble is NOP
    vecs[9]  = '{1'b1, 1'b0, 1'b0, ONES,     1'b0, 64'h0, 0, 1'b0, 64'h0, 3};
    vecs[10] = '{1'b1, 1'b0, 1'b1, PD,       1'b0, 64'h0, 1, 1'b1, PD,    3};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 64'hx,    1'b1, PD,    1, 1'b0, 64'h0, 3}; // X blocked
    vecs[12] = '{1'b1, 1'b0, 1'b1, PE,       1'b0, 64'h0, 1, 1'b1, PE,    3};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 64'h55,   1'b0, 64'h0, 0, 1'b0, 64'h0, 3}; // flush while stalled
    vecs[14] = '{1'b1, 1'b0, 1'b1, PA,       1'b0, 64'h0, 1, 1'b1, PA,    3};
    vecs[15] = '{1'b1, 1'b0, 1'b1, PB,       1'b1, PA,    2, 1'b1, PB,    3};

    // Asynchronous reset with no clock edge involved.
    in_CLR = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_1234_5678);
    #1 in_CLR = 1'b1;
    #1;
    check("rst_v2",   64'(if2.out_valid),     64'h0);
    check("rst_d2",   if2.out_data,           64'h0);
    check("rst_occ2", 64'(if2.out_occ),       64'h0);
    check("rst_cnt2", 64'(if2.out_stall_cnt), 64'h0);
    check("rst_v1",   64'(if1.out_valid),     64'h0);
    check("rst_d1",   if1.out_data,           64'h0);
    check("rst_occ1", 64'(if1.out_occ),       64'h0);
    // Clock edges while reset is held must not load anything.
    edge_step();
    edge_step();
    check("rst_hold_v2", 64'(if2.out_valid), 64'h0);
    check("rst_hold_d1", if1.out_data,       64'h0);

    // Table: the first edge after reset release is a normal edge.
    @(negedge in_CLK);
    in_CLR = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge in_CLK);
      drive(vecs[i].en, vecs[i].flush, vecs[i].valid, vecs[i].data);
      edge_step();
      check($sformatf("v%0d_v2", i),   64'(if2.out_valid),     64'(vecs[i].exp_v2));
      check($sformatf("v%0d_d2", i),   if2.out_data,           vecs[i].exp_d2);
      check($sformatf("v%0d_occ2", i), 64'(if2.out_occ),       64'(vecs[i].exp_occ2));
      check($sformatf("v%0d_cnt2", i), 64'(if2.out_stall_cnt), cnt_exp(vecs[i].exp_cnt));
      check($sformatf("v%0d_v1", i),   64'(if1.out_valid),     64'(vecs[i].exp_v1));
      check($sformatf("v%0d_d1", i),   if1.out_data,           vecs[i].exp_d1);
      check($sformatf("v%0d_cnt1", i), 64'(if1.out_stall_cnt), cnt_exp(vecs[i].exp_cnt));
    end

    // Async reset mid-stream: occ2=2 now. Assert between edges, check before any edge.
    #2 in_CLR = 1'b1;
    #1;
    check("mid_rst_occ2", 64'(if2.out_occ),       64'h0);
    check("mid_rst_d2",   if2.out_data,           64'h0);
    check("mid_rst_v2",   64'(if2.out_valid),     64'h0);
    check("mid_rst_cnt2", 64'(if2.out_stall_cnt), 64'h0);
    check("mid_rst_d1",   if1.out_data,           64'h0);
    check("mid_rst_cnt1", 64'(if1.out_stall_cnt), 64'h0);

    // Saturation on the CNT_W=4 instance: put one valid entry in, then stall 20 edges.
    @(negedge in_CLK);
    in_CLR = 1'b0;
    drive(1'b1, 1'b0, 1'b1, PC);
    edge_step();
    check("sat_occ2", 64'(if2.out_occ), 64'h1);
    @(negedge in_CLK);
    drive(1'b0, 1'b0, 1'b1, 64'h77);
    for (int i = 1; i <= 20; i++) begin
      edge_step();
      if (i == 14) check("sat_cnt14", 64'(if2.out_stall_cnt), cnt_exp(14));
      if (i == 15) check("sat_cnt15", 64'(if2.out_stall_cnt), cnt_exp(15));
    end
    check("sat_cnt20",  64'(if2.out_stall_cnt), cnt_exp(15));
    check("sat_cnt1",   64'(if1.out_stall_cnt), cnt_exp(20));
    check("sat_hold_d2", if2.out_data,          64'h0);
    check("sat_hold_d1", if1.out_data,          PC);
    repeat (2) edge_step();
    check("sat_after", 64'(if2.out_stall_cnt), cnt_exp(15));

    // Flush does not clear the counter.
    @(negedge in_CLK);
    drive(1'b0, 1'b1, 1'b0, 64'h0);
    edge_step();
    check("flush_keep_cnt2", 64'(if2.out_stall_cnt), cnt_exp(15));
    check("flush_keep_cnt1", 64'(if1.out_stall_cnt), cnt_exp(22));
    check("flush_occ1",      64'(if1.out_occ),       64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
